nic_pe_agent: RTL

- Processing-element-side agent that drives one NIC's register interface.
- Injects a programmed burst of 64-bit packets into the ring through the NIC output buffer.
- Drains every packet the NIC has received from the ring through its input buffer.
- Sits directly upstream of each NIC (one instance per node) and replaces hand-driven addr/d_in/nicEn/nicWrEn stimulus.

---
 rtl/nic_pe_agent.sv | 102 ++++++++++
 1 files changed

// File: rtl/nic_pe_agent.sv
// nic_pe_agent: PE-side agent that bursts packets into a NIC and drains its input buffer.
// Optional NIC_PE_AGENT_SEQ_CHECK_EN adds seq_err, a sticky received-sequence checker.
module nic_pe_agent #(
  parameter logic [15:0] SRC_ID   = 16'h0000,
  parameter logic [7:0]  MAX_PKTS = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  num_pkts,
  input  logic        cfg_vc,
  input  logic        cfg_dir,
  input  logic [7:0]  cfg_hops,
  output logic [1:0]  nic_addr,
  output logic [63:0] nic_d_in,
  output logic        nic_en,
  output logic        nic_wr_en,
  input  logic [63:0] nic_d_out,
  output logic        rx_valid,
  output logic [63:0] rx_data,
  output logic [7:0]  tx_count,
  output logic [7:0]  rx_count,
`ifdef NIC_PE_AGENT_SEQ_CHECK_EN
  output logic        seq_err,
`endif
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, POLL_IN, CHK_IN, RD_IN, CAP_IN, POLL_OUT, CHK_OUT, WR_OUT} state_e;
  state_e state_q, state_d;
  logic [7:0] num_q, tx_q, rx_q, hops_q;
  logic vc_q, dir_q, rx_valid_q, full;
  logic [63:0] rx_data_q;
  // Packet bit [k] of the big-endian [0:63] numbering is vector bit 63-k, so status "full" is bit 0.
  assign full = nic_d_out[0];
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = start ? POLL_IN : IDLE;
      POLL_IN:  state_d = CHK_IN;
      CHK_IN:   state_d = full ? RD_IN : (tx_q == num_q) ? IDLE : POLL_OUT;
      RD_IN:    state_d = CAP_IN;
      CAP_IN:   state_d = POLL_IN;
      POLL_OUT: state_d = CHK_OUT;
      CHK_OUT:  state_d = full ? POLL_IN : WR_OUT;
      WR_OUT:   state_d = POLL_IN;
      default:  state_d = IDLE;
    endcase
  end
  assign nic_en    = state_q inside {POLL_IN, RD_IN, POLL_OUT, WR_OUT};
  assign nic_wr_en = state_q == WR_OUT;
  assign nic_addr  = state_q == POLL_IN ? 2'b01 : state_q == POLL_OUT ? 2'b11 : state_q == WR_OUT ? 2'b10 : 2'b00;
  assign nic_d_in  = nic_wr_en ? {vc_q, dir_q, 6'b0, hops_q, SRC_ID, 24'h0, tx_q} : 64'h0;
  assign done      = nic_wr_en && (tx_q + 8'd1 == num_q);
  assign busy      = state_q != IDLE;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign tx_count  = tx_q;
  assign rx_count  = rx_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      num_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      hops_q     <= '0;
      vc_q       <= 1'b0;
      dir_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= state_q == CAP_IN;
      if (state_q == IDLE && start) begin
        num_q  <= num_pkts > MAX_PKTS ? MAX_PKTS : num_pkts;
        vc_q   <= cfg_vc;
        dir_q  <= cfg_dir;
        hops_q <= cfg_hops;
        tx_q   <= '0;
      end
      if (nic_wr_en) tx_q <= tx_q + 8'd1;
      if (state_q == CAP_IN) begin
        rx_data_q <= nic_d_out;
        rx_q      <= rx_q + 8'd1;
      end
    end
  end
`ifdef NIC_PE_AGENT_SEQ_CHECK_EN
  logic [7:0] exp_seq_q;
  logic seq_err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_seq_q <= '0;
      seq_err_q <= 1'b0;
    end else if (state_q == CAP_IN) begin
      exp_seq_q <= exp_seq_q + 8'd1;
      seq_err_q <= seq_err_q | (nic_d_out[7:0] != exp_seq_q);
    end
  end
  assign seq_err = seq_err_q;
`endif
endmodule
